// File: rtl/rib_master_arbiter.sv
// Two-master RIB arbiter (m0 = ibus, m1 = dbus); one transaction in flight, dbus priority with ibus anti-starvation.
// Latency: one arbitration cycle before o_s_req, zero added on the response path; owner backpressure passes straight to o_s_rdy.
module rib_master_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_wrcs,
  input  logic [3:0]  i_m0_mask,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_req,
  output logic        o_m0_gnt,
  output logic        o_m0_rsp,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m0_rdy,

  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_wrcs,
  input  logic [3:0]  i_m1_mask,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_req,
  output logic        o_m1_gnt,
  output logic        o_m1_rsp,
  output logic [31:0] o_m1_rdata,
  input  logic        i_m1_rdy,

  output logic [31:0] o_s_addr,
  output logic        o_s_wrcs,
  output logic [3:0]  o_s_mask,
  output logic [31:0] o_s_wdata,
  output logic        o_s_req,
  input  logic        i_s_gnt,
  input  logic        i_s_rsp,
  input  logic [31:0] i_s_rdata,
  output logic        o_s_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             owner_q, owner_d;   // 0 = m0 (ibus), 1 = m1 (dbus)
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic own_req;
  logic own_rdy;

  // Owner-side selects only; the non-owner never reaches an output.
  assign own_req = owner_q ? i_m1_req : i_m0_req;
  assign own_rdy = owner_q ? i_m1_rdy : i_m0_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;

    o_s_req    = 1'b0;
    o_s_addr   = '0;
    o_s_wrcs   = 1'b0;
    o_s_mask   = '0;
    o_s_wdata  = '0;
    o_s_rdy    = 1'b0;
    o_m0_gnt   = 1'b0;
    o_m1_gnt   = 1'b0;
    o_m0_rsp   = 1'b0;
    o_m1_rsp   = 1'b0;
    o_m0_rdata = '0;
    o_m1_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (i_m0_req || i_m1_req) begin
          state_d = REQ;
          if (i_m0_req && (!i_m1_req || starve_cnt_q >= STARVE_LIM)) begin
            owner_d      = 1'b0;
            starve_cnt_d = '0;
          end else begin
            owner_d = 1'b1;
            // Only a contested loss counts towards ibus starvation.
            if (i_m0_req && starve_cnt_q != CNT_SAT) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
      end

      REQ: begin
        o_s_req = own_req;
        if (owner_q) begin
          o_s_addr  = i_m1_addr;
          o_s_wrcs  = i_m1_wrcs;
          o_s_mask  = i_m1_mask;
          o_s_wdata = i_m1_wdata;
          o_m1_gnt  = i_s_gnt & own_req;
        end else begin
          o_s_addr  = i_m0_addr;
          o_s_wrcs  = i_m0_wrcs;
          o_s_mask  = i_m0_mask;
          o_s_wdata = i_m0_wdata;
          o_m0_gnt  = i_s_gnt & own_req;
        end
        if (!own_req) begin
          state_d = IDLE;
        end else if (i_s_gnt) begin
          state_d = RESP;
        end
      end

      RESP: begin
        o_s_rdy = own_rdy;
        if (owner_q) begin
          o_m1_rsp   = i_s_rsp;
          o_m1_rdata = i_s_rdata;
        end else begin
          o_m0_rsp   = i_s_rsp;
          o_m0_rdata = i_s_rdata;
        end
        if (i_s_rsp && own_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rib_master_arbiter.sv
// Directed vector bench for rib_master_arbiter: cycle table plus arbitration-fairness and async-reset sequences.
module tb_rib_master_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_wrcs, m1_wrcs;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_req, m1_req, m0_rdy, m1_rdy;
  logic        o_m0_gnt, o_m0_rsp, o_m1_gnt, o_m1_rsp;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [31:0] o_s_addr, o_s_wdata;
  logic        o_s_wrcs, o_s_req, o_s_rdy;
  logic [3:0]  o_s_mask;
  logic        s_gnt, s_rsp;
  logic [31:0] s_rdata;

  int checks;
  int failures;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [3:0]  K0 = 4'hF;
  localparam logic [31:0] A1 = 32'h2000_0010;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [3:0]  K1 = 4'h3;

  rib_master_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_m0_addr  (m0_addr),
    .i_m0_wrcs  (m0_wrcs),
    .i_m0_mask  (m0_mask),
    .i_m0_wdata (m0_wdata),
    .i_m0_req   (m0_req),
    .o_m0_gnt   (o_m0_gnt),
    .o_m0_rsp   (o_m0_rsp),
    .o_m0_rdata (o_m0_rdata),
    .i_m0_rdy   (m0_rdy),
    .i_m1_addr  (m1_addr),
    .i_m1_wrcs  (m1_wrcs),
    .i_m1_mask  (m1_mask),
    .i_m1_wdata (m1_wdata),
    .i_m1_req   (m1_req),
    .o_m1_gnt   (o_m1_gnt),
    .o_m1_rsp   (o_m1_rsp),
    .o_m1_rdata (o_m1_rdata),
    .i_m1_rdy   (m1_rdy),
    .o_s_addr   (o_s_addr),
    .o_s_wrcs   (o_s_wrcs),
    .o_s_mask   (o_s_mask),
    .o_s_wdata  (o_s_wdata),
    .o_s_req    (o_s_req),
    .i_s_gnt    (s_gnt),
    .i_s_rsp    (s_rsp),
    .i_s_rdata  (s_rdata),
    .o_s_rdy    (o_s_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req, m1_req, m0_rdy, m1_rdy, s_gnt, s_rsp;
    logic [31:0] s_rdata;
    logic        e_sreq;
    logic [1:0]  e_pay;     // 0 = zero payload, 1 = m0 payload, 2 = m1 payload
    logic        e_m0_gnt, e_m1_gnt, e_m0_rsp, e_m1_rsp;
    logic [31:0] e_m0_rdata, e_m1_rdata;
    logic        e_srdy;
  } vec_t;

  function automatic vec_t mk(
    input logic m0r, input logic m1r, input logic m0y, input logic m1y,
    input logic gnt, input logic rsp, input logic [31:0] rdata,
    input logic esreq, input logic [1:0] epay,
    input logic em0g, input logic em1g, input logic em0r, input logic em1r,
    input logic [31:0] em0d, input logic [31:0] em1d, input logic esrdy);
    vec_t v;
    v.m0_req = m0r;  v.m1_req = m1r;  v.m0_rdy = m0y;  v.m1_rdy = m1y;
    v.s_gnt = gnt;   v.s_rsp = rsp;   v.s_rdata = rdata;
    v.e_sreq = esreq; v.e_pay = epay;
    v.e_m0_gnt = em0g; v.e_m1_gnt = em1g; v.e_m0_rsp = em0r; v.e_m1_rsp = em1r;
    v.e_m0_rdata = em0d; v.e_m1_rdata = em1d; v.e_srdy = esrdy;
    return v;
  endfunction

  function automatic logic [68:0] pay(input logic [1:0] sel);
    case (sel)
      2'd1:    return {A0, 1'b0, K0, D0};
      2'd2:    return {A1, 1'b1, K1, D1};
      default: return '0;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    m0_req = v.m0_req; m1_req = v.m1_req; m0_rdy = v.m0_rdy; m1_rdy = v.m1_rdy;
    s_gnt = v.s_gnt;   s_rsp = v.s_rsp;   s_rdata = v.s_rdata;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [138:0] exp_v, act_v;
    exp_v = {v.e_sreq, pay(v.e_pay), v.e_m0_gnt, v.e_m1_gnt,
             v.e_m0_rsp, v.e_m0_rdata, v.e_m1_rsp, v.e_m1_rdata, v.e_srdy};
    act_v = {o_s_req, o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata, o_m0_gnt, o_m1_gnt,
             o_m0_rsp, o_m0_rdata, o_m1_rsp, o_m1_rdata, o_s_rdy};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  vec_t vecs[20];
  vec_t zv, hold_v;
  logic [1:0] exp_win[14];
  int k;

  initial begin
    checks = 0; failures = 0;
    m0_addr = A0; m0_wrcs = 1'b0; m0_mask = K0; m0_wdata = D0;
    m1_addr = A1; m1_wrcs = 1'b1; m1_mask = K1; m1_wdata = D1;
    m0_req = 0; m1_req = 0; m0_rdy = 0; m1_rdy = 0;
    s_gnt = 0; s_rsp = 0; s_rdata = '0;
    rst = 1'b1;

    zv = mk(0,0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0);
    // m0 alone: arbitrate, wait for gnt, response with 0x13, slave rsp in IDLE ignored
    vecs[0]  = mk(1,0,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 0);
    vecs[1]  = mk(1,0,1,1,0,0,0,          1,1, 0,0,0,0, 0,0, 0);
    vecs[2]  = mk(1,0,1,1,1,0,0,          1,1, 1,0,0,0, 0,0, 0);
    vecs[3]  = mk(0,0,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 1);
    vecs[4]  = mk(0,0,1,1,0,1,32'h13,     0,0, 0,0,1,0, 32'h13,0, 1);
    vecs[5]  = mk(0,0,1,1,0,1,32'h55,     0,0, 0,0,0,0, 0,0, 0);
    // simultaneous request: m1 wins, then response backpressure while m0 waits
    vecs[6]  = mk(1,1,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 0);
    vecs[7]  = mk(1,1,1,1,0,1,32'h66,     1,2, 0,0,0,0, 0,0, 0);
    vecs[8]  = mk(1,1,1,1,1,0,0,          1,2, 0,1,0,0, 0,0, 0);
    vecs[9]  = mk(1,0,1,0,1,1,32'hA5,     0,0, 0,0,0,1, 0,32'hA5, 0);
    vecs[10] = mk(1,0,1,0,1,1,32'hA5,     0,0, 0,0,0,1, 0,32'hA5, 0);
    vecs[11] = mk(1,0,1,0,1,1,32'hA5,     0,0, 0,0,0,1, 0,32'hA5, 0);
    vecs[12] = mk(1,0,1,1,0,1,32'hA5,     0,0, 0,0,0,1, 0,32'hA5, 1);
    // m0 wins, withdraws before gnt (gnt offered as it drops), then m1 runs normally
    vecs[13] = mk(1,0,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 0);
    vecs[14] = mk(1,0,1,1,0,0,0,          1,1, 0,0,0,0, 0,0, 0);
    vecs[15] = mk(0,1,1,1,1,0,0,          0,1, 0,0,0,0, 0,0, 0);
    vecs[16] = mk(0,1,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 0);
    vecs[17] = mk(0,1,1,1,1,0,0,          1,2, 0,1,0,0, 0,0, 0);
    vecs[18] = mk(0,0,1,1,0,1,32'h77,     0,0, 0,0,0,1, 0,32'h77, 1);
    vecs[19] = mk(0,0,1,1,0,0,0,          0,0, 0,0,0,0, 0,0, 0);

    // {m1_gnt, m0_gnt} per grant under continuous contention, counter starting at 0
    for (int i = 0; i < 14; i++) exp_win[i] = 2'b10;
    exp_win[4] = 2'b01;
    exp_win[9] = 2'b01;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", zv);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    apply(mk(1,1,1,1,1,1,0, 0,0, 0,0,0,0, 0,0, 0));
    k = 0;
    for (int c = 0; c < 100 && k < 14; c++) begin
      @(negedge clk);
      if (o_m0_gnt || o_m1_gnt) begin
        checks++;
        if ({o_m1_gnt, o_m0_gnt} !== exp_win[k]) begin
          failures++;
          $display("FAIL winner%0d: got {m1,m0}=%b expected %b", k, {o_m1_gnt, o_m0_gnt}, exp_win[k]);
        end
        k++;
      end
    end
    if (k < 14) begin
      checks++; failures++;
      $display("FAIL winner_timeout: got %0d grants expected 14", k);
    end

    // 14th grant (m1) leaves the counter at 4; stall its response, then reset mid-RESP
    #1;
    hold_v = mk(1,1,1,0,1,1,32'h99, 0,0, 0,0,0,1, 0,32'h99, 0);
    apply(hold_v);
    @(posedge clk);
    @(negedge clk);
    check("resp_stall", hold_v);
    #1 rst = 1'b1;
    #1 check("rst_async", zv);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold", zv);
    #1 rst = 1'b0;

    // a surviving counter of 4 would hand this contested arbitration to m0
    @(posedge clk);
    @(negedge clk);
    check("post_rst_arb", mk(1,1,1,0,1,1,32'h99, 1,2, 0,1,0,0, 0,0, 0));
    @(posedge clk); #1;
    apply(mk(0,0,1,1,0,1,32'h42, 0,0, 0,0,0,1, 0,32'h42, 1));
    @(negedge clk);
    check("post_rst_resp", mk(0,0,1,1,0,1,32'h42, 0,0, 0,0,0,1, 0,32'h42, 1));
    @(posedge clk); #1;
    apply(zv);
    @(negedge clk);
    check("final_idle", zv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
